// File: rtl/fle_pkg.sv
// -----------------------------------------------------------------------------
// fle_pkg
// Shared definitions for the binary32 less-than-or-equal comparator.
// It holds the field widths, a packed view of a binary32 value, and helper
// functions that classify an operand.
//
// Contents:
//   W, EXP_W, MAN_W  operand, exponent and mantissa widths (binary32 only)
//   EXP_MAX          all-ones exponent, used for infinities and NaNs
//   fp32_t           {sign, exp, man} packed view of one operand
//   is_nan()         exponent all ones and mantissa non-zero
//   is_zero()        exponent and mantissa both zero, either sign
//   is_inf()         exponent all ones and mantissa zero
//   magnitude()      the 31 bits below the sign
// -----------------------------------------------------------------------------
package fle_pkg;

    localparam int W     = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    // A NaN has the all-ones exponent and a non-zero mantissa. Quiet and
    // signalling NaNs are treated alike here.
    function automatic logic is_nan(input fp32_t f);
        return (f.exp == EXP_MAX) && (f.man != '0);
    endfunction

    // Both signed zeros count as zero. Denormals do not count as zero
    // because there is no flush-to-zero.
    function automatic logic is_zero(input fp32_t f);
        return (f.exp == '0) && (f.man == '0);
    endfunction

    // Infinities behave as ordinary ordered values in the compare.
    // This helper only makes the classification readable.
    function automatic logic is_inf(input fp32_t f);
        return (f.exp == EXP_MAX) && (f.man == '0);
    endfunction

    // Exponent and mantissa taken together as an unsigned magnitude.
    // In IEEE-754 ordering the larger bit pattern is the larger magnitude.
    function automatic logic [W-2:0] magnitude(input fp32_t f);
        return {f.exp, f.man};
    endfunction

endpackage

// File: rtl/fpu_fle_if.sv
// -----------------------------------------------------------------------------
// fpu_fle_if
// Operand and result bundle for the fpu_fle comparator.
// The master drives the operands and the slave (the comparator) returns the
// registered result one clock later.
//
// Signals:
//   in_valid    x1/x2 are valid this cycle
//   x1, x2      binary32 operands, {sign, exp[7:0], man[22:0]}
//   out_valid   y/exception hold the result of the previous cycle's operands
//   y           1 when x1 <= x2
//   exception   1 when either operand is NaN
//   nan_sticky  only present when FLE_STICKY_NAN_EN is defined
//
// Configuration macro: FLE_STICKY_NAN_EN
// -----------------------------------------------------------------------------
interface fpu_fle_if;
    import fle_pkg::*;

    logic         in_valid;
    logic [W-1:0] x1;
    logic [W-1:0] x2;
    logic         out_valid;
    logic         y;
    logic         exception;
`ifdef FLE_STICKY_NAN_EN
    logic         nan_sticky;
`endif

    // The master side supplies operands (the execute stage or a testbench).
    modport master (
        output in_valid, x1, x2,
`ifdef FLE_STICKY_NAN_EN
        input  nan_sticky,
`endif
        input  out_valid, y, exception
    );

    // The slave side is the comparator itself.
    modport slave (
        input  in_valid, x1, x2,
`ifdef FLE_STICKY_NAN_EN
        output nan_sticky,
`endif
        output out_valid, y, exception
    );

endinterface

// File: rtl/fle_cmp_core.sv
// -----------------------------------------------------------------------------
// fle_cmp_core
// Purely combinational binary32 "x1 <= x2" compare with NaN detection.
//
// Ports:
//   i_x1         operand 1, binary32
//   i_x2         operand 2, binary32
//   o_y          1 when x1 <= x2 (always 0 if either operand is NaN)
//   o_exception  1 when either operand is NaN
// -----------------------------------------------------------------------------
module fle_cmp_core
    import fle_pkg::*;
(
    input  logic [W-1:0] i_x1,
    input  logic [W-1:0] i_x2,
    output logic         o_y,
    output logic         o_exception
);

    fp32_t w_a;
    fp32_t w_b;

    logic  w_anyNan;
    logic  w_bothZero;
    logic  w_magLe;
    logic  w_magGe;

    assign w_a = fp32_t'(i_x1);
    assign w_b = fp32_t'(i_x2);

    assign w_anyNan   = is_nan(w_a) || is_nan(w_b);
    assign w_bothZero = is_zero(w_a) && is_zero(w_b);

    // Sign-magnitude encoding means the 31 bits below the sign order the
    // same way as the values they represent. This holds for denormals and
    // infinities as well, so one unsigned compare covers every non-NaN case
    // with matching signs.
    assign w_magLe = (magnitude(w_a) <= magnitude(w_b));
    assign w_magGe = (magnitude(w_a) >= magnitude(w_b));

    // Rules are applied in priority order. NaN makes the pair unordered.
    // Two zeros are equal regardless of sign. Differing signs are decided by
    // the sign alone. Matching signs use the magnitude compare, and the
    // direction is reversed for negatives.
    always_comb begin
        o_y         = 1'b0;
        o_exception = 1'b0;
        if (w_anyNan) begin
            o_exception = 1'b1;
            o_y         = 1'b0;
        end else if (w_bothZero) begin
            o_y = 1'b1;
        end else if (w_a.sign != w_b.sign) begin
            o_y = w_a.sign;
        end else if (!w_a.sign) begin
            o_y = w_magLe;
        end else begin
            o_y = w_magGe;
        end
    end

endmodule

// File: rtl/fpu_fle.sv
// -----------------------------------------------------------------------------
// fpu_fle
// IEEE-754 binary32 less-than-or-equal comparator for the FPU execute stage.
// It wraps fle_cmp_core with a single register stage, so latency is one clock.
// It has no backpressure, so a new operand pair can be taken every cycle.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   fpu_fle_if.slave: in_valid, x1, x2 -> out_valid, y, exception
//         (and nan_sticky when FLE_STICKY_NAN_EN is defined)
//
// Configuration macro: FLE_STICKY_NAN_EN
//   When defined, bus.nan_sticky is set whenever a valid NaN pair is
//   accepted and stays set until reset.
// -----------------------------------------------------------------------------
module fpu_fle
    import fle_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    fpu_fle_if.slave bus
);

    logic w_cmpY;
    logic w_cmpException;

    logic r_outValid;
    logic r_y;
    logic r_exception;

    fle_cmp_core u_core (
        .i_x1        (bus.x1),
        .i_x2        (bus.x2),
        .o_y         (w_cmpY),
        .o_exception (w_cmpException)
    );

    // Result register. out_valid follows in_valid with a one-cycle delay.
    // y and exception load only on accepted operands. They keep their value
    // through idle cycles, so a consumer that samples late still sees the
    // last result. Reset throws away anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid  <= 1'b0;
            r_y         <= 1'b0;
            r_exception <= 1'b0;
        end else begin
            r_outValid <= bus.in_valid;
            if (bus.in_valid) begin
                r_y         <= w_cmpY;
                r_exception <= w_cmpException;
            end
        end
    end

    assign bus.out_valid = r_outValid;
    assign bus.y         = r_y;
    assign bus.exception = r_exception;

`ifdef FLE_STICKY_NAN_EN
    logic r_nanSticky;

    // Sticky NaN flag. It samples the core's NaN detection directly, so it
    // sets on the same edge that registers the exception. Only reset clears
    // it, which lets software read it once after a long run of compares.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nanSticky <= 1'b0;
        end else if (bus.in_valid && w_cmpException) begin
            r_nanSticky <= 1'b1;
        end
    end

    assign bus.nan_sticky = r_nanSticky;
`endif

endmodule

// File: tb/tb_fpu_fle.sv
// -----------------------------------------------------------------------------
// tb_fpu_fle
// Scoreboard testbench for fpu_fle. Stimulus pushes the expected {exception, y}
// from an ordered-key reference model into a queue. A negedge monitor pops
// and compares whenever out_valid is high, and checks that outputs hold
// while it is low.
// Configuration macro: FLE_STICKY_NAN_EN (adds sticky-flag checks).
// -----------------------------------------------------------------------------
module tb_fpu_fle;

    logic clk;
    logic rst;

    fpu_fle_if bus ();

    fpu_fle dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        y;
        logic        exc;
        logic [31:0] a;
        logic [31:0] b;
    } expect_t;

    expect_t sbQ[$];

    int   nChecks;
    int   nFails;
    logic lastY;
    logic lastExc;

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: every non-NaN value maps onto a signed integer key
    // that orders the same way as the real numbers. Both zeros map to 0,
    // and negatives map to minus their magnitude.
    function automatic logic refIsNan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    function automatic longint refKey(input logic [31:0] v);
        longint mag;
        mag = longint'(v[30:0]);
        return v[31] ? -mag : mag;
    endfunction

    function automatic expect_t refModel(input logic [31:0] a, input logic [31:0] b);
        expect_t e;
        e.a = a;
        e.b = b;
        if (refIsNan(a) || refIsNan(b)) begin
            e.exc = 1'b1;
            e.y   = 1'b0;
        end else begin
            e.exc = 1'b0;
            e.y   = (refKey(a) <= refKey(b));
        end
        return e;
    endfunction

    // One comparison: counts it, and reports a FAIL line on a miss.
    task automatic checkOutput(input string name, input logic actual, input logic expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of operands just after a rising edge. Only valid
    // pairs produce an expected result.
    task automatic applyStimulus(input logic valid, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        bus.in_valid = valid;
        bus.x1       = a;
        bus.x2       = b;
        if (valid) sbQ.push_back(refModel(a, b));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h7FC0_0000, 32'h0);
    endtask

    // Monitor: on each falling edge, check a popped result when out_valid
    // is high. Otherwise check that y and exception still hold.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid === 1'b1) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_out_valid", bus.out_valid, 1'b0);
                end else begin
                    expect_t e;
                    e = sbQ.pop_front();
                    checkOutput($sformatf("y(%h<=%h)", e.a, e.b), bus.y, e.y);
                    checkOutput($sformatf("exception(%h,%h)", e.a, e.b), bus.exception, e.exc);
                    lastY   = e.y;
                    lastExc = e.exc;
                end
            end else begin
                if (sbQ.size() != 0 && sbQ.size() > 1) begin
                    checkOutput("missing_out_valid", bus.out_valid, 1'b1);
                    void'(sbQ.pop_front());
                end
                checkOutput("hold_y", bus.y, lastY);
                checkOutput("hold_exception", bus.exception, lastExc);
            end
        end
    end

`ifdef FLE_STICKY_NAN_EN
    task automatic checkSticky(input string name, input logic expected);
        @(negedge clk);
        checkOutput(name, bus.nan_sticky, expected);
    endtask
`endif

    // Reset asserted between edges while a result is live. The outputs must
    // clear at once, not at the next edge.
    task automatic asyncReset();
        applyStimulus(1'b1, 32'h3F80_0000, 32'h4000_0000);
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        checkOutput("pre_reset_out_valid", bus.out_valid, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_out_valid", bus.out_valid, 1'b0);
        checkOutput("async_rst_y", bus.y, 1'b0);
        checkOutput("async_rst_exception", bus.exception, 1'b0);
        sbQ.delete();
        lastY   = 1'b0;
        lastExc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [31:0] specials[10] = '{
        32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
        32'h7FC0_0000, 32'hFF80_0001, 32'h0000_0001, 32'h8000_0001,
        32'h3F80_0000, 32'h7F7F_FFFF
    };

    // Pick a random operand, mixing special values with fully random bits.
    function automatic logic [31:0] randOperand();
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 9)];
        return $urandom;
    endfunction

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] mask;
        logic [7:0]  e;

        nChecks      = 0;
        nFails       = 0;
        lastY        = 1'b0;
        lastExc      = 1'b0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.x1       = 32'h0;
        bus.x2       = 32'h0;

        #1;
        checkOutput("reset_out_valid", bus.out_valid, 1'b0);
        checkOutput("reset_y", bus.y, 1'b0);
        checkOutput("reset_exception", bus.exception, 1'b0);
`ifdef FLE_STICKY_NAN_EN
        checkOutput("reset_nan_sticky", bus.nan_sticky, 1'b0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] directed ordering, zeros, NaN and infinity");
        applyStimulus(1'b1, 32'h3F80_0000, 32'h4000_0000);
        applyStimulus(1'b1, 32'h4000_0000, 32'h3F80_0000);
        applyStimulus(1'b1, 32'hBF80_0000, 32'hC000_0000);
        applyStimulus(1'b1, 32'hC000_0000, 32'hBF80_0000);
        idle(1);
        applyStimulus(1'b1, 32'h0000_0000, 32'h8000_0000);
        applyStimulus(1'b1, 32'h8000_0000, 32'h0000_0000);
        applyStimulus(1'b1, 32'h3F80_0001, 32'h3F80_0001);
        applyStimulus(1'b1, 32'h0000_0001, 32'h0000_0002);
        applyStimulus(1'b1, 32'h8000_0001, 32'h0000_0000);
        idle(2);
        applyStimulus(1'b1, 32'h7FC0_0000, 32'h3F80_0000);
        idle(1);
        applyStimulus(1'b1, 32'h3F80_0000, 32'hFF80_0001);
        applyStimulus(1'b1, 32'h7F80_0000, 32'h7F80_0000);
        applyStimulus(1'b1, 32'hFF80_0000, 32'h7F7F_FFFF);
        idle(3);

        $display("[TB] same-exponent low mantissa sweep");
        for (int k = 0; k <= 22; k++) begin
            for (int s = 0; s < 4; s++) begin
                e    = 8'($urandom_range(0, 254));
                mask = (32'h1 << k) - 32'h1;
                a    = {s[1], e, 23'($urandom)};
                b    = {s[0], e, a[22:0]};
                b    = (b & ~mask) | (32'($urandom) & mask);
                applyStimulus(1'b1, a, b);
            end
        end
        idle(2);

        $display("[TB] random operands with gaps");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 4) != 0), randOperand(), randOperand());
        end
        idle(2);

        $display("[TB] async reset");
        asyncReset();
        applyStimulus(1'b1, 32'hC000_0000, 32'hBF80_0000);
        idle(2);

`ifdef FLE_STICKY_NAN_EN
        $display("[TB] sticky NaN flag");
        asyncReset();
        checkSticky("sticky_after_reset", 1'b0);
        applyStimulus(1'b1, 32'h7FC0_0000, 32'h3F80_0000);
        applyStimulus(1'b1, 32'h3F80_0000, 32'h4000_0000);
        applyStimulus(1'b1, 32'h4000_0000, 32'h3F80_0000);
        idle(1);
        checkSticky("sticky_stays_set", 1'b1);
        asyncReset();
        checkSticky("sticky_cleared", 1'b0);
        applyStimulus(1'b0, 32'h7FC0_0000, 32'hFF80_0001);
        applyStimulus(1'b0, 32'h7FC0_0000, 32'h7FC0_0000);
        idle(1);
        checkSticky("sticky_ignores_invalid", 1'b0);
        idle(1);
`endif

        checkOutput("scoreboard_drained", (sbQ.size() == 0), 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
